// File: rtl/pe_ws_os.sv
// Systolic MAC processing element: weight-stationary or output-stationary dataflow,
// double-buffered weight on a daisy chain, saturating/wrapping accumulate with sticky overflow.
module pe_ws_os #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int SIGNED = 0,
    parameter int SAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] left,
    input  logic [ACC_W-1:0]  up,
    input  logic [DATA_W-1:0] w_in,
    input  logic              w_shift,
    input  logic              w_swap,
    input  logic              drain,
    output logic [DATA_W-1:0] right,
    output logic              valid_out,
    output logic [ACC_W-1:0]  down,
    output logic              down_valid,
    output logic [DATA_W-1:0] w_out,
    output logic              ovf
);

    localparam int PW = 2 * DATA_W;
    localparam int XW = ACC_W + 1;
    localparam bit IS_SIGNED = (SIGNED != 0);
    localparam bit SAT_EN    = (SAT != 0);

    typedef enum logic {MODE_WS = 1'b0, MODE_OS = 1'b1} mode_e;

    logic [DATA_W-1:0] r_right;
    logic              r_valid_out;
    logic [ACC_W-1:0]  r_down;
    logic              r_down_valid;
    logic [DATA_W-1:0] r_shadow;
    logic [DATA_W-1:0] r_active;
    logic [ACC_W-1:0]  r_acc;
    logic              r_ovf;

    logic [PW-1:0] w_left_x;
    logic [PW-1:0] w_act_x;
    logic [PW-1:0] w_prod;
    logic [XW-1:0] w_prod_x;
    logic [XW-1:0] w_up_x;
    logic [XW-1:0] w_acc_x;
    logic [XW-1:0] w_ws_sum;
    logic [XW-1:0] w_os_sum;
    logic [ACC_W-1:0] w_ws_fix;
    logic [ACC_W-1:0] w_os_fix;
    logic          w_ws_ovf;
    logic          w_os_ovf;
    mode_e         w_mode;

    // Operands are extended to the product width first, so one unsigned multiplier
    // yields the correct low 2*DATA_W bits for both signed and unsigned operation.
    assign w_left_x = {{DATA_W{IS_SIGNED & left[DATA_W-1]}}, left};
    assign w_act_x  = {{DATA_W{IS_SIGNED & r_active[DATA_W-1]}}, r_active};
    assign w_prod   = w_left_x * w_act_x;

    assign w_prod_x = {{(XW-PW){IS_SIGNED & w_prod[PW-1]}}, w_prod};
    assign w_up_x   = {IS_SIGNED & up[ACC_W-1], up};
    assign w_acc_x  = {IS_SIGNED & r_acc[ACC_W-1], r_acc};
    assign w_ws_sum = w_prod_x + w_up_x;
    assign w_os_sum = w_acc_x + w_prod_x;
    assign w_mode   = mode_e'(mode);

    function automatic logic out_of_range(input logic [XW-1:0] x);
        if (IS_SIGNED) return x[XW-1] ^ x[XW-2];
        return x[XW-1];
    endfunction

    function automatic logic [ACC_W-1:0] fix(input logic [XW-1:0] x);
        logic [ACC_W-1:0] y;
        y = x[ACC_W-1:0];
        if (SAT_EN && out_of_range(x)) begin
            if (IS_SIGNED) y = x[XW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            else           y = '1;
        end
        return y;
    endfunction

    assign w_ws_fix = fix(w_ws_sum);
    assign w_os_fix = fix(w_os_sum);
    assign w_ws_ovf = out_of_range(w_ws_sum);
    assign w_os_ovf = out_of_range(w_os_sum);

    // NOTE: state registers use non-blocking assignments so every register samples
    // pre-edge values; this is what lets swap read the old shadow while shift overwrites it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_right      <= '0;
            r_valid_out  <= 1'b0;
            r_down       <= '0;
            r_down_valid <= 1'b0;
            r_shadow     <= '0;
            r_active     <= '0;
            r_acc        <= '0;
            r_ovf        <= 1'b0;
        end else if (en) begin
            r_right      <= left;
            r_valid_out  <= valid_in;
            r_down_valid <= 1'b0;
            if (w_shift) r_shadow <= w_in;
            if (w_swap)  r_active <= r_shadow;

            if (w_mode == MODE_WS) begin
                if (valid_in) begin
                    r_down       <= w_ws_fix;
                    r_down_valid <= 1'b1;
                    if (w_ws_ovf) r_ovf <= 1'b1;
                end
            end else if (drain) begin
                // Restart the next tile with this cycle's product so drains cost no bubble.
                r_down       <= r_acc;
                r_down_valid <= 1'b1;
                r_acc        <= valid_in ? w_prod_x[ACC_W-1:0] : '0;
            end else if (valid_in) begin
                r_acc <= w_os_fix;
                if (w_os_ovf) r_ovf <= 1'b1;
            end
        end
    end

    assign right      = r_right;
    assign valid_out  = r_valid_out;
    assign down       = r_down;
    assign down_valid = r_down_valid;
    assign w_out      = r_shadow;
    assign ovf        = r_ovf;

endmodule
